// File: rtl/pipe_pkg.sv
// Shared types for the pipelined datapath: stage FSM encoding, per-stage payload
// structs with their bubble words, and the saturating-increment helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pstate_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_t;

    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        alu_op_t     alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } memwb_t;

    // Bubbles are architecturally inert: no register write, no memory access.
    localparam ifid_t IFID_BUBBLE = '{pc: 32'd0, instr: NOP_INSTR};
    localparam idex_t IDEX_BUBBLE = '{pc: 32'd0, rs1_val: 32'd0, rs2_val: 32'd0, imm: 32'd0,
                                      rd: 5'd0, opcode: OP_RTYPE, alu_op: ALU_ADD,
                                      reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0};
    localparam exmem_t EXMEM_BUBBLE = '{alu_res: 32'd0, rs2_val: 32'd0, rd: 5'd0,
                                        reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0};
    localparam memwb_t MEMWB_BUBBLE = '{wb_val: 32'd0, rd: 5'd0, reg_we: 1'b0};

    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic inc);
        return (inc && (val != 32'hFFFF_FFFF)) ? (val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall/bubble cycle counters for one pipeline stage.
// Present only when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        clr,
    input  logic        stall_evt,
    input  logic        bubble_evt,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_cycles
);

    // Counter pair; clear takes priority over counting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles  <= 32'd0;
            bubble_cycles <= 32'd0;
        end else if (clr) begin
            stall_cycles  <= 32'd0;
            bubble_cycles <= 32'd0;
        end else begin
            stall_cycles  <= sat_inc32(stall_cycles, stall_evt);
            bubble_cycles <= sat_inc32(bubble_cycles, bubble_evt);
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall, flush and optional 2-entry skid.
// Define PIPE_STAGE_PERF_EN to add perf_clr, stall_cycles and bubble_cycles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter bit                SKID_EN   = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
`ifdef PIPE_STAGE_PERF_EN
    input  logic              perf_clr,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles,
`endif
    output logic [1:0]        occupancy
);

    pstate_t           state_r, state_s;
    logic [DATA_W-1:0] main_r, main_s;
    logic [DATA_W-1:0] skid_r, skid_s;
    logic              in_ready_r;
    logic              accept_s, emit_s;

    // main_r is forced to FLUSH_VAL whenever the stage goes empty, so out_data is a pure register.
    assign out_valid = (state_r != PS_EMPTY);
    assign out_data  = main_r;
    assign occupancy = state_r;
    assign accept_s  = in_valid & in_ready;
    assign emit_s    = out_valid & out_ready & ~stall;

    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = in_ready_r;
        end else begin : g_comb_ready
            assign in_ready = (state_r == PS_EMPTY) | (out_ready & ~stall);
        end
    endgenerate

    // Next-state and payload steering; flush overrides every transfer.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = PS_EMPTY;
            main_s  = FLUSH_VAL;
            skid_s  = FLUSH_VAL;
        end else begin
            case (state_r)
                PS_EMPTY: begin
                    if (accept_s) begin
                        state_s = PS_ONE;
                        main_s  = in_data;
                    end else begin
                        state_s = PS_EMPTY;
                    end
                end
                PS_ONE: begin
                    if (accept_s && emit_s) begin
                        main_s = in_data;
                    end else if (accept_s && SKID_EN) begin
                        state_s = PS_TWO;
                        skid_s  = in_data;
                    end else if (emit_s) begin
                        state_s = PS_EMPTY;
                        main_s  = FLUSH_VAL;
                    end else begin
                        state_s = PS_ONE;
                    end
                end
                PS_TWO: begin
                    if (emit_s) begin
                        state_s = PS_ONE;
                        main_s  = skid_r;
                        skid_s  = FLUSH_VAL;
                    end else begin
                        state_s = PS_TWO;
                    end
                end
                default: begin
                    state_s = PS_EMPTY;
                    main_s  = FLUSH_VAL;
                    skid_s  = FLUSH_VAL;
                end
            endcase
        end
    end

    // State, payload and registered ready (ready mirrors the next state).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= PS_EMPTY;
            main_r     <= FLUSH_VAL;
            skid_r     <= FLUSH_VAL;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            main_r     <= main_s;
            skid_r     <= skid_s;
            in_ready_r <= (state_s != PS_TWO);
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_perf (
        .CLK           (CLK),
        .nRST          (nRST),
        .clr           (perf_clr),
        .stall_evt     (out_valid & stall),
        .bubble_evt    (~out_valid),
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + randomized bench for pipe_stage_reg with a FIFO scoreboard of accepted payloads.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] FV     = 32'h0000_0013;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic              perf_clr;
    logic [31:0]       stall_cycles, bubble_cycles;
`endif

    logic [31:0] sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(DATA_W), .FLUSH_VAL(FV), .SKID_EN(1'b1)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .stall         (stall),
        .flush         (flush),
`ifdef PIPE_STAGE_PERF_EN
        .perf_clr      (perf_clr),
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles),
`endif
        .occupancy     (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes of this cycle at the falling edge, then step past the rising edge.
    task automatic cycle();
        logic [31:0] exp;
        @(negedge CLK);
        if (out_valid && out_ready && !stall) begin
            exp = 'x;
            if (sb.size() != 0) exp = sb.pop_front();
            chk("emit_data", out_data, exp);
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"},  out_data, FV);
        chk({tag, "_occ"},   {30'd0, occupancy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        nRST = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        perf_clr = 1'b0;
`endif
        #12;
        chk_empty("reset");
        @(posedge CLK); #1;
        nRST = 1'b1; in_valid = 1'b0;
        cycle();
        chk_empty("post_reset");

        // streaming
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'(i);
            cycle();
            chk("stream_data", out_data, 32'(i));
            chk("stream_occ", {30'd0, occupancy}, 32'd1);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk_empty("stream_drain");

        // backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        cycle();
        in_data = 32'hB;
        cycle();
        chk("skid_occ", {30'd0, occupancy}, 32'd2);
        chk("skid_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_head", out_data, 32'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("skid_ready_after_emit", {31'd0, in_ready}, 32'd1);
        chk("skid_second", out_data, 32'hB);
        cycle();
        chk_empty("skid_drain");

        // stall holds contents
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
        repeat (3) begin
            cycle();
            chk("stall_hold", out_data, 32'h5);
            chk("stall_occ", {30'd0, occupancy}, 32'd1);
        end
        stall = 1'b0;
        cycle();
        chk_empty("stall_release");
        chk("stall_sb", sb.size(), 32'd0);

        // flush with full stage, stall and pending input
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        cycle();
        in_data = 32'h12;
        cycle();
        flush = 1'b1; stall = 1'b1; in_data = 32'h7;
        cycle();
        chk_empty("flush_full");
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // flush drops a same-cycle accept but the same-cycle emit still counts
        in_valid = 1'b1; in_data = 32'h21; out_ready = 1'b0;
        cycle();
        out_ready = 1'b1; in_data = 32'h22; flush = 1'b1;
        cycle();
        chk_empty("flush_accept");
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_accept_gone", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-transfer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31;
        cycle();
        in_valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk_empty("async_reset");
        sb.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        perf_clr = 1'b1;
        cycle();
        perf_clr = 1'b0; in_valid = 1'b1; in_data = 32'h9; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0; stall = 1'b1;
        repeat (4) cycle();
        stall = 1'b0; flush = 1'b1;
        repeat (2) cycle();
        flush = 1'b0;
        chk("perf_stall", stall_cycles, 32'd4);
        chk("perf_bubble_ge2", {31'd0, bubble_cycles >= 32'd2}, 32'd1);
        perf_clr = 1'b1;
        cycle();
        perf_clr = 1'b0;
        chk("perf_clr_stall", stall_cycles, 32'd0);
        chk("perf_clr_bubble", bubble_cycles, 32'd0);
`endif

        // randomized traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
            chk("rand_occ", {30'd0, occupancy}, sb.size());
            chk("rand_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
        end

        // bounded drain
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
        chk("drain_sb", sb.size(), 32'd0);
        chk_empty("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the pipelined datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload with a valid/ready handshake, a stall input, a flush input and a 2-entry skid buffer.
- Upstream can deassert nothing combinationally: in_ready is registered, so the stage breaks ready-path timing.
- Flushed or empty slots present a programmable bubble word (FLUSH_VAL) downstream instead of stale data.

Parameters:
- DATA_W, 128, payload width in bits (stage's packed control + data fields).
- FLUSH_VAL, '0, DATA_W-bit bubble word driven on out_data when out_valid=0 (e.g. NOP encoding, ALU op = ADD).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, in_ready = !full | (out_ready & !stall).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload valid to downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  payload, FLUSH_VAL when !out_valid
- stall  in  1  hazard-unit freeze; holds contents, blocks output transfer
- flush  in  1  squash all held entries (branch/jump resolve)
- occupancy  out  2  entries held (0..2)

Behaviour:
- Reset (async, nRST=0): state EMPTY, out_valid=0, out_data=FLUSH_VAL, in_ready=1, occupancy=0, skid entry = FLUSH_VAL.
- Transfers: accept = in_valid & in_ready. Emit = out_valid & out_ready & !stall.
- FSM (SKID_EN=1), states EMPTY / ONE / TWO:
  - EMPTY: accept -> ONE (main <= in_data).
  - ONE: accept & !emit -> TWO (skid <= in_data). accept & emit -> ONE (main <= in_data). emit only -> EMPTY.
  - TWO: emit -> ONE (main <= skid). No accept is possible because in_ready=0.
- in_ready is a register: 1 in EMPTY and ONE, 0 in TWO. It updates with state, so it reflects the next state.
- Latency: 1 cycle from accept to out_valid when empty. FIFO order is preserved; no payload is lost or duplicated.
- Stall: equivalent to forcing out_ready=0. Accepts still proceed into free entries. Stall does not clear anything.
- Flush (highest priority): next state EMPTY, occupancy=0, out_data=FLUSH_VAL, in_ready=1.
  - A same-cycle accept is dropped. Upstream sees the handshake complete and must also flush.
  - A same-cycle emit still counts downstream, because out_valid was high in that cycle.
- flush & stall together: flush wins.
- Reset mid-transfer: all entries discarded immediately (async).
- SKID_EN=0: states EMPTY / ONE only. in_ready is combinational as given in Parameters. Same flush/stall rules.
- out_data is driven only from the main register. It is never combinational from in_data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and bubble_cycles[31:0]. Both are saturating counters, reset to 0 by nRST and cleared by a new input perf_clr.
  - stall_cycles increments on every cycle with out_valid & stall.
  - bubble_cycles increments on every cycle with !out_valid, including flush cycles.
  - Saturate at 32'hFFFF_FFFF.
- Undefined: these ports and the counter logic do not exist. All other behaviour is identical.

Decomposition:
- Package pipe_pkg: typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pstate_t.
- Package pipe_pkg also holds the per-stage packed payload structs (ifid_t, idex_t, exmem_t, memwb_t) and their bubble constants (e.g. IDEX_BUBBLE with ALU_ADD, opcode RTYPE).
- Instantiating stages use $bits(idex_t) for DATA_W and the struct constant for FLUSH_VAL.
- Optional sub-module pipe_perf_cnt holds the saturating counter pair. It is instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: nRST=0 while in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=FLUSH_VAL, in_ready=1, occupancy=0. Holds for 1 cycle after release with no input.
- Streaming: out_ready=1, feed 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy=1 throughout, in_ready stays 1.
- Backpressure/skid: out_ready=0, send 0xA then 0xB -> occupancy=2, in_ready=0. Then out_ready=1 -> 0xA, then 0xB emitted in order; in_ready=1 the cycle after the first emit.
- Stall: occupancy=1 holding 0x5, stall=1 for 3 cycles with out_ready=1 -> out_data stays 0x5, no emit. Stall=0 -> 0x5 emitted once.
- Flush priority: occupancy=2, flush=1 with in_valid=1, in_data=0x7, stall=1 -> next cycle out_valid=0, out_data=FLUSH_VAL, occupancy=0, in_ready=1, and 0x7 never appears.
- Perf (macro on): 4 stall cycles with valid data plus 2 flush cycles -> stall_cycles=4, bubble_cycles>=2. perf_clr -> both 0.
